imm_gen_pipe: RTL and testbench

//   Registered, parametrised immediate generator for the decode stage, with valid/ready in and out.

---
 rtl/imm_gen_pipe_if.sv | 26 ++
 rtl/imm_gen_pipe.sv | 145 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Decode-to-issue handshake bundle for the immediate generator: instruction/PC in,
// decoded immediate, format, PC-relative target and illegal flag out.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with pc+imm precompute and an optional
// 2-entry skid buffer (SKID=1) that keeps in_ready registered at full throughput.
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    imm_gen_pipe_if.slave  bus
);
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    logic [31:0]     inst;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z, imm_sh, imm_sh32;

    assign inst     = bus.in_inst;
    assign opcode   = inst[6:0];
    assign funct3   = inst[14:12];
    assign imm_i    = XLEN'($signed(inst[31:20]));
    assign imm_s    = XLEN'($signed({inst[31:25], inst[11:7]}));
    assign imm_b    = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u    = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j    = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    assign imm_z    = XLEN'(inst[19:15]);
    assign imm_sh   = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
    assign imm_sh32 = XLEN'(inst[24:20]);

    entry_t dec;
    logic   pc_rel;

    // NOTE: every output of this block is given a default first so no path infers a latch.
    always_comb begin
        dec    = '0;
        pc_rel = 1'b0;
        // Opcodes all end in 2'b11, so a bad inst[1:0] falls through to default.
        case (opcode)
            OP_LOAD, OP_JALR, OP_FENCE: begin dec.fmt = FMT_I; dec.imm = imm_i; end
            OP_IMM: begin
                dec.fmt = FMT_I;
                dec.imm = (funct3[1:0] == 2'b01) ? imm_sh : imm_i;
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    dec.fmt = FMT_I;
                    dec.imm = (funct3[1:0] == 2'b01) ? imm_sh32 : imm_i;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_SYSTEM: begin
                dec.fmt = funct3[2] ? FMT_Z : FMT_I;
                dec.imm = funct3[2] ? imm_z : imm_i;
            end
            OP_STORE:         begin dec.fmt = FMT_S; dec.imm = imm_s; end
            OP_BRANCH:        begin dec.fmt = FMT_B; dec.imm = imm_b; pc_rel = 1'b1; end
            OP_LUI:           begin dec.fmt = FMT_U; dec.imm = imm_u; end
            OP_AUIPC:         begin dec.fmt = FMT_U; dec.imm = imm_u; pc_rel = 1'b1; end
            OP_JAL:           begin dec.fmt = FMT_J; dec.imm = imm_j; pc_rel = 1'b1; end
            OP_OP:            dec.fmt = FMT_NONE;
            OP_OP32:          dec.illegal = (XLEN != 64);
            default:          dec.illegal = 1'b1;
        endcase
        dec.target = pc_rel ? bus.in_pc + dec.imm : '0;
    end

    logic   o_valid, s_valid, rdy_q;
    entry_t o_ent, s_ent;
    logic   out_free, accept;

    assign out_free     = !o_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign bus.in_ready = !rst && ((SKID != 0) ? rdy_q : out_free);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            s_valid <= 1'b0;
            rdy_q   <= 1'b1;
            o_ent   <= '0;
        end else if (flush) begin
            o_valid <= 1'b0;
            s_valid <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            if (out_free) begin
                if (s_valid) begin
                    o_valid <= 1'b1;
                    o_ent   <= s_ent;
                    s_valid <= 1'b0;
                end else begin
                    o_valid <= accept;
                    if (accept) o_ent <= dec;
                end
            end else if (accept && SKID != 0) begin
                s_valid <= 1'b1;
            end
            // Skid stays (or becomes) occupied only while the output is stalled.
            rdy_q <= out_free || !(accept || s_valid);
        end
    end

    // NOTE: the skid payload has no reset; s_valid alone says whether it means anything.
    always_ff @(posedge clk) begin
        if (!out_free && accept) s_ent <= dec;
    end

    assign bus.out_valid   = o_valid;
    assign bus.out_imm     = o_ent.imm;
    assign bus.out_fmt     = o_ent.fmt;
    assign bus.out_target  = o_ent.target;
    assign bus.out_illegal = o_ent.illegal;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32/SKID=1 and an XLEN=64/SKID=0 instance share stimulus,
// each scored against a queue-based model of the decode rules and the handshake.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [63:0] in_pc = '0;
    logic        out_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64)) bus64 ();

    assign bus32.in_valid  = in_valid;
    assign bus32.in_inst   = in_inst;
    assign bus32.in_pc     = in_pc[31:0];
    assign bus32.out_ready = out_ready;
    assign bus64.in_valid  = in_valid;
    assign bus64.in_inst   = in_inst;
    assign bus64.in_pc     = in_pc;
    assign bus64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .SKID(1)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(bus32));
    imm_gen_pipe #(.XLEN(64), .SKID(0)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(bus64));

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [63:0] target;
        logic        illegal;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Two's-complement reading of the low 'bits' bits of v.
    function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
        return v[bits-1] ? v - (64'd1 << bits) : v;
    endfunction

    function automatic exp_t ref_model(input logic [31:0] i, input logic [63:0] p, input int xlen);
        exp_t        e;
        logic [63:0] mask, imm;
        logic [2:0]  f3;
        logic        bad, rel;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        f3   = i[14:12];
        imm  = 0;
        bad  = 0;
        e.fmt = 0;
        case (i[6:0])
            7'h03, 7'h67, 7'h0F: begin e.fmt = 1; imm = sext(i >> 20, 12); end
            7'h13: begin
                e.fmt = 1;
                imm = (f3 == 1 || f3 == 5) ? ((i >> 20) & (xlen - 1)) : sext(i >> 20, 12);
            end
            7'h1B: begin
                if (xlen == 32) bad = 1;
                else begin
                    e.fmt = 1;
                    imm = (f3 == 1 || f3 == 5) ? ((i >> 20) & 31) : sext(i >> 20, 12);
                end
            end
            7'h73: begin
                e.fmt = (f3 >= 4) ? 6 : 1;
                imm = (f3 >= 4) ? ((i >> 15) & 31) : sext(i >> 20, 12);
            end
            7'h23: begin e.fmt = 2; imm = sext({i[31:25], i[11:7]}, 12); end
            7'h63: begin e.fmt = 3; imm = sext({i[31], i[7], i[30:25], i[11:8], 1'b0}, 13); end
            7'h37, 7'h17: begin e.fmt = 4; imm = sext(i & 32'hFFFF_F000, 32); end
            7'h6F: begin e.fmt = 5; imm = sext({i[31], i[19:12], i[20], i[30:21], 1'b0}, 21); end
            7'h33: e.fmt = 0;
            7'h3B: bad = (xlen == 32);
            default: bad = 1;
        endcase
        rel = (i[6:0] == 7'h63) || (i[6:0] == 7'h6F) || (i[6:0] == 7'h17);
        if (bad) begin
            e.fmt = 0;
            imm   = 0;
            rel   = 0;
        end
        e.illegal = bad;
        e.imm     = imm & mask;
        e.target  = rel ? ((p + imm) & mask) : 0;
        return e;
    endfunction

    // One clock: drive after the edge, then score the DUT state at the falling edge.
    task automatic step(input logic v, input logic [31:0] i = 0, input logic [63:0] p = 0,
                        input logic ordy = 1, input logic fl = 0, input logic r = 0);
        logic was_rst, rdy32, rdy64;
        exp_t e;
        @(posedge clk);
        was_rst = rst;
        #1;
        in_valid  = v;
        in_inst   = i;
        in_pc     = p;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(negedge clk);
        rdy32 = !r && (q32.size() < 2);
        rdy64 = !r && (q64.size() == 0 || ordy);
        check("rdy32", bus32.in_ready, rdy32);
        check("rdy64", bus64.in_ready, rdy64);
        if (q32.size() != 0) begin
            e = q32[0];
            check("valid32", bus32.out_valid, 1'b1);
            check("imm32", bus32.out_imm, e.imm);
            check("fmt32", bus32.out_fmt, e.fmt);
            check("tgt32", bus32.out_target, e.target);
            check("ill32", bus32.out_illegal, e.illegal);
        end else begin
            check("valid32", bus32.out_valid, 1'b0);
            if (was_rst)
                check("rstout32", {bus32.out_imm, bus32.out_target, bus32.out_fmt, bus32.out_illegal}, 0);
        end
        if (q64.size() != 0) begin
            e = q64[0];
            check("valid64", bus64.out_valid, 1'b1);
            check("imm64", bus64.out_imm, e.imm);
            check("fmt64", bus64.out_fmt, e.fmt);
            check("tgt64", bus64.out_target, e.target);
            check("ill64", bus64.out_illegal, e.illegal);
        end else begin
            check("valid64", bus64.out_valid, 1'b0);
            if (was_rst) begin
                check("rstimm64", bus64.out_imm, 0);
                check("rsttgt64", bus64.out_target, 0);
                check("rstfmt64", {bus64.out_fmt, bus64.out_illegal}, 0);
            end
        end
        if (r || fl) begin
            q32.delete();
            q64.delete();
        end else begin
            if (q32.size() != 0 && ordy) void'(q32.pop_front());
            if (v && rdy32) q32.push_back(ref_model(i, p, 32));
            if (q64.size() != 0 && ordy) void'(q64.pop_front());
            if (v && rdy64) q64.push_back(ref_model(i, p, 64));
        end
    endtask

    int unsigned ops[13] = '{'h03, 'h13, 'h67, 'h0F, 'h73, 'h1B, 'h23, 'h63, 'h37, 'h17, 'h6F, 'h33, 'h3B};

    initial begin
        // Reset
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        step(0);
        check("rst_rdy_after", bus32.in_ready, 1'b1);

        // Tests 1-3, back to back
        step(1, 32'hFFF0_0093, 64'h0);
        step(1, 32'hFE00_0EE3, 64'h100);
        check("t1_imm", bus32.out_imm, 32'hFFFF_FFFF);
        check("t1_fmt", bus32.out_fmt, 3'd1);
        check("t1_ill", bus32.out_illegal, 1'b0);
        step(1, 32'h0080_006F, 64'hFFFF_FFFC);
        check("t2_imm", bus32.out_imm, 32'hFFFF_FFFC);
        check("t2_fmt", bus32.out_fmt, 3'd3);
        check("t2_tgt", bus32.out_target, 32'h0000_00FC);
        step(0);
        check("t3_imm", bus32.out_imm, 32'd8);
        check("t3_fmt", bus32.out_fmt, 3'd5);
        check("t3_tgt", bus32.out_target, 32'h0000_0004);
        step(0);

        // Test 4: stall with three back-to-back offers, then release
        step(1, 32'h0010_0093, 0, 0);
        step(1, 32'h0020_0093, 0, 0);
        step(1, 32'h0030_0093, 0, 0);
        check("t4_rdy_low", bus32.in_ready, 1'b0);
        check("t4_hold", bus32.out_imm, 32'd1);
        step(1, 32'h0030_0093, 0, 0);
        check("t4_stable", bus32.out_imm, 32'd1);
        step(1, 32'h0030_0093, 0, 1);
        check("t4_first", bus32.out_imm, 32'd1);
        step(1, 32'h0030_0093, 0, 1);
        check("t4_second", bus32.out_imm, 32'd2);
        step(0);
        check("t4_third", bus32.out_imm, 32'd3);
        step(0);
        check("t4_done", bus32.out_valid, 1'b0);

        // Test 5: flush during the same stall
        step(1, 32'h0010_0093, 0, 0);
        step(1, 32'h0020_0093, 0, 0);
        step(1, 32'h0030_0093, 0, 0);
        step(1, 32'h0040_0093, 0, 0, 1);
        step(0);
        check("t5_valid", bus32.out_valid, 1'b0);
        check("t5_rdy", bus32.in_ready, 1'b1);
        repeat (3) step(0);

        // Test 6: RV64 cases
        step(1, 32'h8000_0537, 64'h0);
        step(1, 32'h03F5_1513, 64'h0);
        check("t6_lui", bus64.out_imm, 64'hFFFF_FFFF_8000_0000);
        check("t6_lui_fmt", bus64.out_fmt, 3'd4);
        step(1, 32'h0000_0000, 64'h0);
        check("t6_shamt", bus64.out_imm, 64'h3F);
        step(0);
        check("t6_ill", bus64.out_illegal, 1'b1);
        check("t6_ill_imm", bus64.out_imm, 64'h0);

        // Randomized traffic with occasional flush and reset
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] r, inst;
            int unsigned k;
            r = $urandom();
            k = $urandom_range(0, 15);
            inst = {r[31:7], (k < 13) ? ops[k][6:0] : r[6:0]};
            if ($urandom_range(0, 15) == 0) inst[1:0] = 2'($urandom_range(0, 2));
            step($urandom_range(0, 9) < 7, inst, {$urandom(), $urandom()},
                 $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0, $urandom_range(0, 299) == 0);
        end
        repeat (4) step(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
